// File: rtl/ysyx_22050058_ifu_if.sv
// Instruction-memory fetch bus between the IFU (master) and instruction
// memory (slave).
//   req    : fetch request valid (master -> slave)
//   addr   : fetch address       (master -> slave)
//   ready  : request accepted this cycle (slave -> master)
//   rvalid : response data valid (slave -> master)
//   rdata  : fetched instruction  (slave -> master)
interface ysyx_22050058_ifu_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned INST_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ready;
    logic              rvalid;
    logic [INST_W-1:0] rdata;

    modport master (
        output req, addr,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, addr,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/ysyx_22050058_ifu.sv
// Instruction-fetch stage feeding the IF/ID register. Owns the PC, issues
// one outstanding fetch at a time over imem, presents {pc, dnpc, inst} and
// requests a pipeline stall until an instruction is ready. A redirect from
// EX reloads the PC and squashes any in-flight fetch.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   stall_i[5:0]      : ctrl stall vector, bit 0 holds this stage
//   redirect_valid_i  : one-cycle redirect pulse
//   redirect_pc_i     : redirect target
//   imem (master)     : req/addr/ready/rvalid/rdata fetch bus
//   stallreq_o        : fetch not ready
//   if_pc_o/if_dnpc_o/if_inst_o : presented instruction (zero when bubble)
//   if_misalign_o     : only with YSYX_22050058_IFU_MISALIGN_TRAP_EN defined;
//                       flags a presented misaligned redirect target
//
// Optional feature macro: YSYX_22050058_IFU_MISALIGN_TRAP_EN
module ysyx_22050058_ifu #(
    parameter int unsigned          ADDR_W     = 64,
    parameter int unsigned          INST_W     = 32,
    parameter logic [ADDR_W-1:0]    RST_VECTOR = 64'h0000_0000_8000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall_i,
    input  logic                    redirect_valid_i,
    input  logic [ADDR_W-1:0]       redirect_pc_i,
    ysyx_22050058_ifu_if.master     imem,
    output logic                    stallreq_o,
    output logic [ADDR_W-1:0]       if_pc_o,
    output logic [ADDR_W-1:0]       if_dnpc_o,
    output logic [INST_W-1:0]       if_inst_o
`ifdef YSYX_22050058_IFU_MISALIGN_TRAP_EN
    ,
    output logic                    if_misalign_o
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc_r, pc_n;
    logic [INST_W-1:0] inst_r, inst_n;
    logic              accept;

    // Only the IF bit of the ctrl stall vector matters here.
    logic              unused_stall;
    assign unused_stall = ^stall_i[5:1];

`ifdef YSYX_22050058_IFU_MISALIGN_TRAP_EN
    logic              mis_r, mis_n;
    logic              redirect_mis;
    assign redirect_mis = (redirect_pc_i[1:0] != 2'b00);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FETCH;
            pc_r   <= RST_VECTOR;
            inst_r <= '0;
`ifdef YSYX_22050058_IFU_MISALIGN_TRAP_EN
            mis_r  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            pc_r   <= pc_n;
            inst_r <= inst_n;
`ifdef YSYX_22050058_IFU_MISALIGN_TRAP_EN
            mis_r  <= mis_n;
`endif
        end
    end

    assign imem.req  = (state == S_FETCH) && !redirect_valid_i;
    assign imem.addr = pc_r;
    assign accept    = imem.req && imem.ready;

    always_comb begin
        state_n = state;
        pc_n    = pc_r;
        inst_n  = inst_r;
        if (redirect_valid_i) begin
            pc_n = redirect_pc_i;
            case (state)
                // An outstanding response must still be drained unless it
                // lands on this very cycle.
                S_WAIT, S_DROP: state_n = imem.rvalid ? S_FETCH : S_DROP;
                default:        state_n = S_FETCH;
            endcase
`ifdef YSYX_22050058_IFU_MISALIGN_TRAP_EN
            if (redirect_mis) begin
                state_n = S_VALID;
                inst_n  = '0;
            end
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    if (accept) state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (imem.rvalid) begin
                        inst_n  = imem.rdata;
                        state_n = S_VALID;
                    end
                end
                S_VALID: begin
                    if (!stall_i[0]) begin
                        pc_n    = pc_r + ADDR_W'(4);
                        state_n = S_FETCH;
                    end
                end
                default: begin
                    if (imem.rvalid) state_n = S_FETCH;
                end
            endcase
        end
    end

`ifdef YSYX_22050058_IFU_MISALIGN_TRAP_EN
    // Flag survives only while the misaligned entry stays presented.
    always_comb begin
        mis_n = 1'b0;
        if (state_n == S_VALID) begin
            mis_n = redirect_valid_i ? redirect_mis : mis_r;
        end
    end
    assign if_misalign_o = (state == S_VALID) && mis_r;
`endif

    assign stallreq_o = (state != S_VALID);
    assign if_pc_o    = (state == S_VALID) ? pc_r : '0;
    assign if_dnpc_o  = (state == S_VALID) ? (pc_r + ADDR_W'(4)) : '0;
    assign if_inst_o  = (state == S_VALID) ? inst_r : '0;

endmodule

// File: tb/tb_ysyx_22050058_ifu.sv
// Randomised scoreboard bench for ysyx_22050058_ifu. A transaction-level
// model tracks the outstanding fetch, the expected fetch PC and whether an
// instruction is being presented; live responses are queued and a separate
// monitor pops them when the IFU starts presenting.
module tb_ysyx_22050058_ifu;

    localparam logic [63:0] RSTV = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst;
    logic [5:0]  stall_i;
    logic        redirect_valid_i;
    logic [63:0] redirect_pc_i;
    logic        stallreq_o;
    logic [63:0] if_pc_o;
    logic [63:0] if_dnpc_o;
    logic [31:0] if_inst_o;
`ifdef YSYX_22050058_IFU_MISALIGN_TRAP_EN
    logic        if_misalign_o;
`endif

    ysyx_22050058_ifu_if #(.ADDR_W(64), .INST_W(32)) imem ();

    ysyx_22050058_ifu #(
        .ADDR_W    (64),
        .INST_W    (32),
        .RST_VECTOR(RSTV)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .imem            (imem.master),
        .stallreq_o      (stallreq_o),
        .if_pc_o         (if_pc_o),
        .if_dnpc_o       (if_dnpc_o),
        .if_inst_o       (if_inst_o)
`ifdef YSYX_22050058_IFU_MISALIGN_TRAP_EN
        ,
        .if_misalign_o   (if_misalign_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        bit          mis;
    } entry_t;

    entry_t exp_q[$];
    int     n_vec = 0;
    int     n_mis = 0;

    // Transaction-level model state
    bit          pending;
    bit          pend_live;
    logic [63:0] pend_addr;
    logic [63:0] exp_pc;
    bit          presenting;
    logic [63:0] cur_pc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check and advance
    // the model shortly after, the DUT commits on the following rising edge.
    task automatic cycle(input bit r, input logic [63:0] rpc, input logic [5:0] s,
                         input bit rdy, input bit rv, input logic [31:0] rd, input bit rs);
        bit   exp_req;
        bit   was_presenting;
        entry_t e;
        @(negedge clk);
        rst              = rs;
        redirect_valid_i = r;
        redirect_pc_i    = rpc;
        stall_i          = s;
        imem.ready       = rdy;
        imem.rvalid      = rv;
        imem.rdata       = rd;
        #1;
        if (rs) begin
            pending    = 0;
            pend_live  = 0;
            presenting = 0;
            exp_pc     = RSTV;
            exp_q.delete();
        end else begin
            exp_req = !pending && !presenting && !r;
            check("imem_req", {63'd0, imem.req}, {63'd0, exp_req});
            if (exp_req) check("imem_addr", imem.addr, exp_pc);
            check("stallreq", {63'd0, stallreq_o}, {63'd0, !presenting});
            was_presenting = presenting;
            if (rv && pending) begin
                pending = 0;
                if (pend_live && !r) begin
                    e.pc = pend_addr; e.inst = rd; e.mis = 0;
                    exp_q.push_back(e);
                    presenting = 1;
                    cur_pc     = pend_addr;
                end
            end
            if (exp_req && rdy) begin
                pending   = 1;
                pend_live = 1;
                pend_addr = exp_pc;
            end
            if (r) begin
                pend_live  = 0;
                exp_pc     = rpc;
                presenting = 0;
`ifdef YSYX_22050058_IFU_MISALIGN_TRAP_EN
                if (rpc[1:0] != 2'b00) begin
                    e.pc = rpc; e.inst = 32'd0; e.mis = 1;
                    exp_q.push_back(e);
                    presenting = 1;
                    cur_pc     = rpc;
                end
`endif
            end else if (was_presenting && !s[0]) begin
                presenting = 0;
                exp_pc     = cur_pc + 64'd4;
            end
        end
    endtask

    // Monitor: pops a new expectation on each start of presentation.
    entry_t mon_cur;
    bit     prev_stall = 1'b1;
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (!stallreq_o) begin
                if (prev_stall) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_mis++;
                        $display("FAIL present_unexpected: got pc %h expected no instruction", if_pc_o);
                    end else begin
                        mon_cur = exp_q.pop_front();
                    end
                end
                check("if_pc", if_pc_o, mon_cur.pc);
                check("if_dnpc", if_dnpc_o, mon_cur.pc + 64'd4);
                check("if_inst", {32'd0, if_inst_o}, {32'd0, mon_cur.inst});
`ifdef YSYX_22050058_IFU_MISALIGN_TRAP_EN
                check("if_misalign", {63'd0, if_misalign_o}, {63'd0, mon_cur.mis});
`endif
            end else begin
                check("bubble_pc", if_pc_o, 64'd0);
                check("bubble_dnpc", if_dnpc_o, 64'd0);
                check("bubble_inst", {32'd0, if_inst_o}, 64'd0);
`ifdef YSYX_22050058_IFU_MISALIGN_TRAP_EN
                check("bubble_misalign", {63'd0, if_misalign_o}, 64'd0);
`endif
            end
        end
        prev_stall = stallreq_o;
    end

    initial begin
        bit          r, rdy, rv, rs;
        logic [63:0] rpc;
        rst = 1'b1; stall_i = '0; redirect_valid_i = 1'b0; redirect_pc_i = '0;
        imem.ready = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
        pending = 0; pend_live = 0; presenting = 0; exp_pc = RSTV; cur_pc = '0; pend_addr = '0;

        // Reset, then a minimum-latency fetch
        cycle(0, 64'd0, 6'd0, 0, 0, 32'd0, 1);
        cycle(0, 64'd0, 6'd0, 0, 0, 32'd0, 1);
        cycle(0, 64'd0, 6'd0, 1, 0, 32'd0, 0);
        cycle(0, 64'd0, 6'd0, 1, 1, 32'h0000_0413, 0);
        // Presented; hold it for 3 cycles
        cycle(0, 64'd0, 6'd1, 1, 0, 32'd0, 0);
        check("first_inst", {32'd0, if_inst_o}, 64'h0000_0413);
        check("first_dnpc", if_dnpc_o, 64'h0000_0000_8000_0004);
        cycle(0, 64'd0, 6'd1, 1, 0, 32'd0, 0);
        cycle(0, 64'd0, 6'd1, 1, 0, 32'd0, 0);
        check("held_pc", if_pc_o, RSTV);
        cycle(0, 64'd0, 6'd0, 1, 0, 32'd0, 0);
        cycle(0, 64'd0, 6'd0, 1, 0, 32'd0, 0);
        check("second_addr", imem.addr, 64'h0000_0000_8000_0004);
        // Redirect while waiting; late response must be dropped
        cycle(1, 64'h0000_0000_8000_0100, 6'd0, 0, 0, 32'd0, 0);
        cycle(0, 64'd0, 6'd0, 0, 0, 32'd0, 0);
        cycle(0, 64'd0, 6'd0, 0, 1, 32'hDEAD_BEEF, 0);
        cycle(0, 64'd0, 6'd0, 0, 0, 32'd0, 0);
        check("redirect_addr", imem.addr, 64'h0000_0000_8000_0100);
        // Redirect in FETCH together with ready
        cycle(1, 64'h0000_0000_8000_0200, 6'd0, 1, 0, 32'd0, 0);
        cycle(0, 64'd0, 6'd0, 1, 0, 32'd0, 0);
        // Reset while waiting, then a stale response
        cycle(0, 64'd0, 6'd0, 0, 0, 32'd0, 1);
        cycle(0, 64'd0, 6'd0, 0, 1, 32'h1234_5678, 0);
        cycle(0, 64'd0, 6'd0, 1, 0, 32'd0, 0);
        check("post_reset_addr", imem.addr, RSTV);
        cycle(0, 64'd0, 6'd0, 0, 1, 32'h0000_0013, 0);
        cycle(0, 64'd0, 6'd0, 0, 0, 32'd0, 0);
`ifdef YSYX_22050058_IFU_MISALIGN_TRAP_EN
        // Misaligned redirect from FETCH presents a trap entry directly
        cycle(1, 64'h0000_0000_8000_0102, 6'd0, 1, 0, 32'd0, 0);
        cycle(0, 64'd0, 6'd1, 1, 0, 32'd0, 0);
        check("mis_flag", {63'd0, if_misalign_o}, 64'd1);
        check("mis_pc", if_pc_o, 64'h0000_0000_8000_0102);
        check("mis_inst", {32'd0, if_inst_o}, 64'd0);
        cycle(0, 64'd0, 6'd0, 1, 0, 32'd0, 0);
`endif

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 9) == 0);
            rpc = 64'h0000_0000_8000_0000 + 64'({$urandom_range(0, 255), 2'b00});
            if ($urandom_range(0, 15) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFFC;
            if (!pending && !presenting && $urandom_range(0, 3) == 0)
                rpc[1:0] = 2'($urandom_range(1, 3));
            rdy = ($urandom_range(0, 9) < 6);
            rv  = pending ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
            rs  = ($urandom_range(0, 299) == 0);
            cycle(r, rpc, 6'($urandom), rdy, rv, $urandom, rs);
        end
        cycle(0, 64'd0, 6'd0, 0, 0, 32'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
